// File: rtl/bcd_opg_sched.sv
// Round-robin scheduler sharing one serial BCD odd-parity generator among N_REQ requesters.
// Digits are shifted MSB-first into the OPG; each result is returned with the requester ID and cross-checked locally.
module bcd_opg_sched #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] digit,
    output logic [N_REQ-1:0]   ack,
    output logic               opg_x,
    output logic               opg_rst_n,
    input  logic               opg_z,
    output logic               res_valid,
    output logic               res_parity,
    output logic [ID_W-1:0]    res_id,
    output logic               res_err,
    output logic               res_mismatch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_REJECT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic [3:0]        dig_p1, dig_d;
    logic [ID_W-1:0]   id_p1, id_d;

    logic [N_REQ-1:0]  ack_d;
    logic              opg_x_d, opg_rst_n_d;
    logic              res_valid_d, res_parity_d, res_err_d, res_mismatch_d;
    logic [ID_W-1:0]   res_id_d;

    logic [2*N_REQ-1:0] req_rot;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_off, gnt_idx;
    logic [ID_W:0]      gnt_sum, ptr_sum;
    logic [3:0]         gnt_digit;
    logic [N_REQ-1:0]   gnt_onehot;

    function automatic logic odd_parity(input logic [3:0] d);
        return ~^d;
    endfunction

    // Rotate requests so the pointer position lands at bit 0; the lowest set bit is the winner.
    assign req_rot = {req, req} >> ptr_q;

    always_comb begin
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                gnt_found = 1'b1;
                gnt_off   = ID_W'(j);
            end
        end
        gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= (ID_W+1)'(N_REQ)) begin
            gnt_sum = gnt_sum - (ID_W+1)'(N_REQ);
        end
        gnt_idx = gnt_sum[ID_W-1:0];
    end

    always_comb begin
        gnt_digit  = 4'd0;
        gnt_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (gnt_idx == ID_W'(j)) begin
                gnt_digit     = digit[4*j +: 4];
                gnt_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_sum = {1'b0, id_p1} + (ID_W+1)'(1);
        if (ptr_sum >= (ID_W+1)'(N_REQ)) begin
            ptr_sum = '0;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        ptr_d          = ptr_q;
        dig_d          = dig_p1;
        id_d           = id_p1;
        ack_d          = '0;
        opg_x_d        = 1'b0;
        opg_rst_n_d    = 1'b0;
        res_valid_d    = 1'b0;
        res_parity_d   = res_parity;
        res_id_d       = res_id;
        res_err_d      = res_err;
        res_mismatch_d = res_mismatch;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ack_d = gnt_onehot;
                    dig_d = gnt_digit;
                    id_d  = gnt_idx;
                    if (gnt_digit > 4'd9) begin
                        state_d = S_REJECT;
                    end else begin
                        state_d     = S_SHIFT;
                        k_d         = 2'd0;
                        opg_rst_n_d = 1'b1;
                        opg_x_d     = gnt_digit[3];
                    end
                end
            end
            S_SHIFT: begin
                if (k_q == 2'd3) begin
                    // opg_z is Mealy: it already reflects the fourth bit driven this cycle.
                    state_d        = S_DONE;
                    res_valid_d    = 1'b1;
                    res_parity_d   = opg_z;
                    res_mismatch_d = (opg_z != odd_parity(dig_p1));
                    res_err_d      = 1'b0;
                    res_id_d       = id_p1;
                end else begin
                    k_d         = k_q + 2'd1;
                    opg_rst_n_d = 1'b1;
                    opg_x_d     = dig_p1[2'd2 - k_q];
                end
            end
            S_REJECT: begin
                state_d        = S_DONE;
                res_valid_d    = 1'b1;
                res_parity_d   = 1'b0;
                res_mismatch_d = 1'b0;
                res_err_d      = 1'b1;
                res_id_d       = id_p1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = ptr_sum[ID_W-1:0];
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            ptr_q        <= '0;
            ack          <= '0;
            opg_x        <= 1'b0;
            opg_rst_n    <= 1'b0;
            res_valid    <= 1'b0;
            res_parity   <= 1'b0;
            res_id       <= '0;
            res_err      <= 1'b0;
            res_mismatch <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            ptr_q        <= ptr_d;
            ack          <= ack_d;
            opg_x        <= opg_x_d;
            opg_rst_n    <= opg_rst_n_d;
            res_valid    <= res_valid_d;
            res_parity   <= res_parity_d;
            res_id       <= res_id_d;
            res_err      <= res_err_d;
            res_mismatch <= res_mismatch_d;
        end
    end

    // Latched digit and ID are only consumed after a grant, so they need no reset.
    always_ff @(posedge clock) begin
        dig_p1 <= dig_d;
        id_p1  <= id_d;
    end

endmodule

// File: tb/tb_bcd_opg_sched.sv
// Directed bench for bcd_opg_sched with a behavioural serial OPG and a result scoreboard.
module tb_bcd_opg_sched;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req   = '0;
    logic [7:0]       digit = '0;
    logic [1:0]       ack;
    logic             opg_x, opg_rst_n, opg_z;
    logic             res_valid, res_parity, res_err, res_mismatch;
    logic [ID_W-1:0]  res_id;

    logic opg_acc  = 1'b0;
    logic force_z0 = 1'b0;

    typedef struct {
        int   id;
        logic parity;
        logic err;
        logic mismatch;
    } exp_t;

    exp_t exp_q[$];

    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   res_cyc = 0;
    logic got_res = 1'b0;

    bcd_opg_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .digit        (digit),
        .ack          (ack),
        .opg_x        (opg_x),
        .opg_rst_n    (opg_rst_n),
        .opg_z        (opg_z),
        .res_valid    (res_valid),
        .res_parity   (res_parity),
        .res_id       (res_id),
        .res_err      (res_err),
        .res_mismatch (res_mismatch)
    );

    always #5 clock = ~clock;

    // Serial odd-parity generator: Mealy output covers the bit currently presented.
    always @(posedge clock) begin
        if (!opg_rst_n) opg_acc <= 1'b0;
        else            opg_acc <= opg_acc ^ opg_x;
    end
    assign opg_z = force_z0 ? 1'b0 : ~(opg_acc ^ opg_x);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        got_res = 1'b0;
        if (res_valid) begin
            got_res = 1'b1;
            res_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_res_valid", 32'(res_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("res_id",       32'(res_id),       32'(e.id));
                check("res_parity",   32'(res_parity),   32'(e.parity));
                check("res_err",      32'(res_err),      32'(e.err));
                check("res_mismatch", 32'(res_mismatch), 32'(e.mismatch));
            end
        end
    endtask

    task automatic push_exp(input int id, input logic [3:0] d);
        exp_t e;
        logic p;
        p          = ~^d;
        e.id       = id;
        e.err      = (d > 4'd9);
        e.parity   = e.err ? 1'b0 : (force_z0 ? 1'b0 : p);
        e.mismatch = !e.err && force_z0 && p;
        exp_q.push_back(e);
    endtask

    // One complete transaction from a single requester, with cycle-exact checks.
    task automatic serve(input int id, input logic [3:0] d);
        logic [1:0] oh;
        logic [3:0] bits;
        oh = (id == 0) ? 2'b01 : 2'b10;
        push_exp(id, d);
        req = req | oh;
        if (id == 0) digit[3:0] = d;
        else         digit[7:4] = d;
        step();
        check("ack_grant", 32'(ack), 32'(oh));
        req = req & ~oh;
        if (d <= 4'd9) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin
                    step();
                    check("ack_pulse", 32'(ack), 32'(0));
                end
                bits = d >> (3 - k);
                check("shift_rst_n", 32'(opg_rst_n), 32'(1));
                check("shift_x",     32'(opg_x),     32'(bits[0]));
            end
            step();
            check("res_valid_lat", 32'(res_valid), 32'(1));
            check("done_rst_n",    32'(opg_rst_n), 32'(0));
            step();
            check("res_valid_pulse", 32'(res_valid), 32'(0));
        end else begin
            check("rej_rst_n", 32'(opg_rst_n), 32'(0));
            check("rej_x",     32'(opg_x),     32'(0));
            step();
            check("rej_res_valid", 32'(res_valid), 32'(1));
            check("rej_rst_n2",    32'(opg_rst_n), 32'(0));
            check("rej_x2",        32'(opg_x),     32'(0));
            check("rej_ack",       32'(ack),       32'(0));
            step();
            check("rej_res_pulse", 32'(res_valid), 32'(0));
        end
    endtask

    initial begin
        int n_ack;
        int nres;
        int prev;

        // Reset state.
        repeat (3) step();
        check("rst_ack",        32'(ack),          32'(0));
        check("rst_opg_x",      32'(opg_x),        32'(0));
        check("rst_opg_rst_n",  32'(opg_rst_n),    32'(0));
        check("rst_res_valid",  32'(res_valid),    32'(0));
        check("rst_res_parity", 32'(res_parity),   32'(0));
        check("rst_res_id",     32'(res_id),       32'(0));
        check("rst_res_err",    32'(res_err),      32'(0));
        check("rst_res_mism",   32'(res_mismatch), 32'(0));
        reset = 1'b1;
        step();

        // Single requests and the full digit range.
        serve(0, 4'd3);
        serve(1, 4'd7);
        for (int d = 0; d < 10; d++) serve(d % 2, 4'(d));

        // Fairness with both requesters held high.
        push_exp(0, 4'd5);
        push_exp(1, 4'd8);
        push_exp(0, 4'd5);
        push_exp(1, 4'd8);
        digit = {4'd8, 4'd5};
        req   = 2'b11;
        n_ack = 0;
        nres  = 0;
        prev  = 0;
        for (int c = 0; c < 40 && nres < 4; c++) begin
            step();
            if (ack != 2'b00) begin
                check("fair_ack", 32'(ack), (n_ack % 2 == 0) ? 32'h1 : 32'h2);
                n_ack++;
            end
            if (got_res) begin
                if (nres > 0) check("fair_interval", 32'(res_cyc - prev), 32'd6);
                prev = res_cyc;
                nres++;
                if (nres == 4) req = 2'b00;
            end
        end
        check("fair_results", 32'(nres), 32'd4);
        step();

        // Invalid BCD, then forced and correct OPG output for digit 0.
        serve(0, 4'd12);
        force_z0 = 1'b1;
        serve(0, 4'd0);
        force_z0 = 1'b0;
        serve(0, 4'd0);

        // Reset in IDLE returns the pointer to 0 (it was 1).
        reset = 1'b0;
        step();
        check("idle_rst_ack", 32'(ack), 32'(0));
        reset = 1'b1;
        push_exp(0, 4'd2);
        push_exp(1, 4'd9);
        digit = {4'd9, 4'd2};
        req   = 2'b11;
        step();
        check("ptr_reset_ack", 32'(ack), 32'h1);
        req[0] = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step();
            if (ack == 2'b10) req[1] = 1'b0;
        end
        check("ptr_reset_drain", 32'(exp_q.size()), 32'(0));
        step();

        // Reset during SHIFT k=2 drops the frame; pending req[1] is served afterwards.
        digit[3:0] = 4'd6;
        req[0]     = 1'b1;
        step();
        check("mid_ack", 32'(ack), 32'h1);
        req[0] = 1'b0;
        step();
        step();
        check("mid_k2_x", 32'(opg_x), 32'(1));
        reset      = 1'b0;
        req[1]     = 1'b1;
        digit[7:4] = 4'd4;
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_rst_ack",   32'(ack),       32'(0));
            check("mid_rst_rst_n", 32'(opg_rst_n), 32'(0));
            check("mid_rst_x",     32'(opg_x),     32'(0));
            check("mid_rst_valid", 32'(res_valid), 32'(0));
        end
        reset = 1'b1;
        serve(1, 4'd4);

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
